// File: rtl/lcd_hex_display.sv
// HD44780 16x2 driver: power-up init, then renders a 128-bit value as
// 32 uppercase hex characters (bits 127:64 on line 1, 63:0 on line 2).
module lcd_hex_display #(
    parameter int SETUP_CYCLES      = 2,
    parameter int E_HIGH_CYCLES     = 12,
    parameter int CMD_WAIT_CYCLES   = 2000,
    parameter int CLEAR_WAIT_CYCLES = 82000,
    parameter int POWERUP_CYCLES    = 750000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] value,
    output logic         busy,
    output logic         done,
    output logic         lcd_rw,
    output logic         lcd_e,
    output logic         lcd_rs,
    output logic [7:0]   data
);

    typedef enum logic [2:0] {
        ST_PWRUP, ST_INIT, ST_IDLE, ST_DRAW, ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        PH_OFF, PH_SETUP, PH_EHIGH, PH_WAIT
    } phase_t;

    localparam logic [31:0] SETUP_LAST = 32'(SETUP_CYCLES - 1);
    localparam logic [31:0] EHIGH_LAST = 32'(E_HIGH_CYCLES - 1);
    localparam logic [31:0] CMD_LAST   = 32'(CMD_WAIT_CYCLES - 1);
    localparam logic [31:0] CLEAR_LAST = 32'(CLEAR_WAIT_CYCLES - 1);
    // Counting starts on the first edge with rst low, hence no -1 here.
    localparam logic [31:0] PWRUP_END  = 32'(POWERUP_CYCLES);

    state_t         state_q, state_d;
    phase_t         phase_q, phase_d;
    logic [31:0]    cnt_q, cnt_d;
    logic [5:0]     idx_q, idx_d;
    logic [127:0]   val_q, val_d;
    logic           rs_q, rs_d;
    logic [7:0]     data_q, data_d;

    logic [5:0]     nidx;
    logic [4:0]     pos;
    logic [3:0]     nib;
    logic           nxt_rs;
    logic [7:0]     nxt_byte;
    logic [31:0]    wait_last;
    logic           last_byte;

    function automatic logic [7:0] to_ascii(input logic [3:0] n);
        return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
    endfunction

    // Byte that follows the current one in the active sequence.
    always_comb begin
        nidx     = (state_q == ST_INIT || state_q == ST_DRAW)
                   ? idx_q + 6'd1 : 6'd0;
        pos      = (nidx <= 6'd16) ? 5'(6'd32 - nidx) : 5'(6'd33 - nidx);
        nib      = val_q[{pos, 2'b00} +: 4];
        nxt_rs   = 1'b0;
        nxt_byte = 8'h00;
        if (state_q == ST_DRAW) begin
            if (nidx == 6'd17) begin
                nxt_byte = 8'hC0;
            end else begin
                nxt_rs   = 1'b1;
                nxt_byte = to_ascii(nib);
            end
        end else begin
            unique case (nidx[1:0])
                2'd0: nxt_byte = 8'h38;
                2'd1: nxt_byte = 8'h0C;
                2'd2: nxt_byte = 8'h06;
                2'd3: nxt_byte = 8'h01;
            endcase
        end
    end

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        cnt_d     = cnt_q + 32'd1;
        idx_d     = idx_q;
        val_d     = val_q;
        rs_d      = rs_q;
        data_d    = data_q;
        wait_last = (!rs_q && data_q == 8'h01) ? CLEAR_LAST : CMD_LAST;
        last_byte = (state_q == ST_INIT) ? (idx_q == 6'd3)
                                         : (idx_q == 6'd33);
        unique case (state_q)
            ST_PWRUP: begin
                if (cnt_q == PWRUP_END) begin
                    state_d = ST_INIT;
                    phase_d = PH_SETUP;
                    cnt_d   = '0;
                    idx_d   = '0;
                    rs_d    = nxt_rs;
                    data_d  = nxt_byte;
                end
            end
            ST_INIT, ST_DRAW: begin
                unique case (phase_q)
                    PH_SETUP: begin
                        if (cnt_q == SETUP_LAST) begin
                            phase_d = PH_EHIGH;
                            cnt_d   = '0;
                        end
                    end
                    PH_EHIGH: begin
                        if (cnt_q == EHIGH_LAST) begin
                            phase_d = PH_WAIT;
                            cnt_d   = '0;
                        end
                    end
                    PH_WAIT: begin
                        if (cnt_q == wait_last) begin
                            cnt_d = '0;
                            if (last_byte) begin
                                phase_d = PH_OFF;
                                state_d = (state_q == ST_INIT)
                                          ? ST_IDLE : ST_DONE;
                            end else begin
                                phase_d = PH_SETUP;
                                idx_d   = nidx;
                                rs_d    = nxt_rs;
                                data_d  = nxt_byte;
                            end
                        end
                    end
                    default: begin
                        phase_d = PH_SETUP;
                        cnt_d   = '0;
                    end
                endcase
            end
            ST_IDLE: begin
                cnt_d = '0;
                if (start) begin
                    val_d   = value;
                    state_d = ST_DRAW;
                    phase_d = PH_SETUP;
                    idx_d   = '0;
                    rs_d    = 1'b0;
                    data_d  = 8'h80;
                end
            end
            ST_DONE: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_PWRUP;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_PWRUP;
            phase_q <= PH_OFF;
            cnt_q   <= '0;
            idx_q   <= '0;
            val_q   <= '0;
            rs_q    <= 1'b0;
            data_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            val_q   <= val_d;
            rs_q    <= rs_d;
            data_q  <= data_d;
        end
    end

    assign lcd_rw = 1'b0;
    assign lcd_e  = (phase_q == PH_EHIGH);
    assign lcd_rs = rs_q;
    assign data   = data_q;
    assign busy   = (state_q != ST_IDLE);
    assign done   = (state_q == ST_DONE);

endmodule

// File: tb/tb_lcd_hex_display.sv
// Scoreboard bench for lcd_hex_display: expected LCD bytes are queued by
// the stimulus, a negedge monitor pops them on each E rise and checks timing.
module tb_lcd_hex_display;

    logic         clk;
    logic         rst;
    logic         start;
    logic [127:0] value;
    logic         busy;
    logic         done;
    logic         lcd_rw;
    logic         lcd_e;
    logic         lcd_rs;
    logic [7:0]   data;

    lcd_hex_display #(
        .SETUP_CYCLES      (1),
        .E_HIGH_CYCLES     (2),
        .CMD_WAIT_CYCLES   (4),
        .CLEAR_WAIT_CYCLES (8),
        .POWERUP_CYCLES    (10)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .value  (value),
        .busy   (busy),
        .done   (done),
        .lcd_rw (lcd_rw),
        .lcd_e  (lcd_e),
        .lcd_rs (lcd_rs),
        .data   (data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;
    logic [8:0] exp_q[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push_init();
        exp_q.push_back(9'h038);
        exp_q.push_back(9'h00C);
        exp_q.push_back(9'h006);
        exp_q.push_back(9'h001);
    endtask

    task automatic push_draw(input string l1, input string l2);
        exp_q.push_back(9'h080);
        for (int i = 0; i < 16; i++) exp_q.push_back({1'b1, l1[i]});
        exp_q.push_back(9'h0C0);
        for (int i = 0; i < 16; i++) exp_q.push_back({1'b1, l2[i]});
    endtask

    task automatic wait_busy_low(input int limit, output int t);
        t = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (!busy) begin
                t = cyc;
                break;
            end
        end
        if (t < 0) chk("busy_low_timeout", 1, 0);
    endtask

    task automatic wait_done(input int limit, output int t);
        t = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (done) begin
                t = cyc;
                break;
            end
        end
        if (t < 0) chk("done_timeout", 1, 0);
    endtask

    // Monitor state
    logic       prev_e   = 1'b0;
    logic [8:0] prev_bus = '0;
    logic [8:0] held     = '0;
    logic [8:0] bus;
    logic [8:0] exp_b;
    int hi_cnt    = 0;
    int low_cnt   = 0;
    int wait_prev = 0;
    bit in_burst  = 0;
    int rw_bad    = 0;
    int done_cnt  = 0;

    always @(negedge clk) begin
        if (lcd_rw !== 1'b0) rw_bad++;
        if (rst) begin
            prev_e   = 1'b0;
            in_burst = 0;
            hi_cnt   = 0;
            low_cnt  = 0;
        end else begin
            bus = {lcd_rs, data};
            if (done) done_cnt++;
            if (lcd_e && !prev_e) begin
                chk("setup_stable", bus, prev_bus);
                if (in_burst) chk("byte_gap", low_cnt, wait_prev + 1);
                if (exp_q.size() == 0) begin
                    chk("unexpected_byte", bus, 0);
                end else begin
                    exp_b = exp_q.pop_front();
                    chk("byte", bus, exp_b);
                end
                held   = bus;
                hi_cnt = 1;
            end else if (lcd_e) begin
                hi_cnt++;
                chk("hold_ehigh", bus, held);
            end else begin
                if (prev_e) begin
                    chk("e_width", hi_cnt, 2);
                    low_cnt   = 1;
                    in_burst  = 1;
                    wait_prev = (held == 9'h001) ? 8 : 4;
                end else begin
                    low_cnt++;
                end
                if (in_burst && low_cnt <= wait_prev)
                    chk("hold_wait", bus, held);
            end
            if (!busy) in_burst = 0;
            prev_e   = lcd_e;
            prev_bus = bus;
        end
    end

    localparam logic [127:0] V1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] V2 = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [127:0] V3 = 128'hdeadbeefcafef00d13579bdf02468ace;

    initial begin
        int t0, ta, t, d0;
        bit found;
        logic pe;

        rst   = 1'b1;
        start = 1'b0;
        value = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_lcd_e", lcd_e, 0);
        chk("rst_lcd_rs", lcd_rs, 0);
        chk("rst_lcd_rw", lcd_rw, 0);
        chk("rst_data", data, 0);
        chk("rst_busy", busy, 1);
        chk("rst_done", done, 0);

        // Power-up and init sequence
        push_init();
        @(posedge clk); #1 rst = 1'b0;
        t0 = cyc + 1;
        wait_busy_low(200, t);
        chk("init_busy_fall", t - t0, 42);

        // FIPS-197 plaintext
        push_draw("0011223344556677", "8899AABBCCDDEEFF");
        d0 = done_cnt;
        @(posedge clk); #1 start = 1'b1; value = V1;
        ta = cyc + 1;
        @(posedge clk); #1 start = 1'b0;
        wait_done(400, t);
        chk("fips_done_latency", t - ta, 238);
        @(negedge clk);
        chk("fips_busy_after_done", busy, 0);
        chk("fips_done_width", done, 0);
        chk("fips_done_count", done_cnt - d0, 1);

        // All nibbles, start held through the redraw, value changed mid-way
        push_draw("0123456789ABCDEF", "FEDCBA9876543210");
        d0 = done_cnt;
        @(posedge clk); #1 start = 1'b1; value = V2;
        ta = cyc + 1;
        repeat (50) @(posedge clk);
        #1 value = ~V2;
        wait_done(400, t);
        start = 1'b0;
        chk("nib_done_latency", t - ta, 238);
        repeat (20) @(negedge clk);
        chk("nib_done_count", done_cnt - d0, 1);
        chk("nib_busy_idle", busy, 0);
        chk("nib_queue_empty", exp_q.size(), 0);

        // start held through reset and init: one redraw only
        @(posedge clk); #1 rst = 1'b1; start = 1'b1; value = V3;
        repeat (2) @(posedge clk);
        push_init();
        push_draw("DEADBEEFCAFEF00D", "13579BDF02468ACE");
        d0 = done_cnt;
        #1 rst = 1'b0;
        t0 = cyc + 1;
        wait_busy_low(200, t);
        chk("held_init_busy_fall", t - t0, 42);
        repeat (10) @(negedge clk);
        value = ~V3;
        wait_done(400, t);
        start = 1'b0;
        chk("held_done_latency", t - t0, 281);
        repeat (20) @(negedge clk);
        chk("held_done_count", done_cnt - d0, 1);
        chk("held_queue_empty", exp_q.size(), 0);

        // Reset while E is high mid-redraw
        push_draw("0011223344556677", "8899AABBCCDDEEFF");
        @(posedge clk); #1 start = 1'b1; value = V1;
        @(posedge clk); #1 start = 1'b0;
        found = 0;
        pe    = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (lcd_e && !pe && exp_q.size() < 20) begin
                found = 1;
                break;
            end
            pe = lcd_e;
        end
        chk("midpulse_found", found, 1);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("midrst_lcd_e", lcd_e, 0);
        chk("midrst_lcd_rs", lcd_rs, 0);
        chk("midrst_data", data, 0);
        chk("midrst_busy", busy, 1);
        chk("midrst_done", done, 0);
        exp_q.delete();
        push_init();
        @(posedge clk); #1 rst = 1'b0;
        t0 = cyc + 1;
        wait_busy_low(200, t);
        chk("reinit_busy_fall", t - t0, 42);
        repeat (5) @(negedge clk);
        chk("final_queue_empty", exp_q.size(), 0);
        chk("lcd_rw_always_low", rw_bad, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lcd_hex_display.md
# lcd_hex_display

Sequential driver that takes the 128-bit plaintext produced by the `Decrypt` stage and renders it as 32 uppercase hex characters on an HD44780-compatible 16x2 character LCD. It sits directly downstream of `Decrypt` and owns the board's `lcd_rw`/`lcd_e`/`lcd_rs`/`data` pins. It runs the LCD power-up initialisation sequence itself, then redraws the display on each `start` request. Bits 127:64 go on line 1 and bits 63:0 on line 2, most significant nibble first.

## Interface
- `SETUP_CYCLES`, default 2: cycles with RS/data valid and E low before each E pulse (min 1).
- `E_HIGH_CYCLES`, default 12: cycles E is held high per byte (min 1).
- `CMD_WAIT_CYCLES`, default 2000: cycles after E falls before the next byte, all bytes except clear (min 1).
- `CLEAR_WAIT_CYCLES`, default 82000: post-E wait after the clear command 0x01 (min 1).
- `POWERUP_CYCLES`, default 750000: wait after reset before the first init byte (min 1).
- `clk`  in  1  system clock; all logic is on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request a redraw; sampled only in IDLE.
- `value`  in  128  plaintext from `Decrypt`; captured on the accepting edge.
- `busy`  out  1  high during init and during a redraw.
- `done`  out  1  one-cycle pulse when a redraw completes.
- `lcd_rw`  out  1  LCD R/W; constant 0 (write-only).
- `lcd_e`  out  1  LCD enable strobe.
- `lcd_rs`  out  1  LCD register select: 0 = command, 1 = character.
- `data`  out  8  LCD data bus DB7..DB0.

## Operation
- Decided: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values:
  - `lcd_e`=0, `lcd_rs`=0, `lcd_rw`=0, `data`=8'h00.
  - `busy`=1, `done`=0.
  - State is PWRUP and all counters are cleared.
- States: PWRUP, INIT, IDLE, DRAW, DONE.
  - Each byte is sent by a byte sub-sequencer with phases SETUP, EHIGH and WAIT.
- PWRUP: count POWERUP_CYCLES, then go to INIT.
- INIT: send the commands 0x38, 0x0C, 0x06, 0x01 in that order, all with RS=0. Then go to IDLE and drop `busy`.
- IDLE: `busy`=0. If `start`=1 on an edge, latch `value` into an internal register, set `busy`=1 and go to DRAW.
- DRAW sends 34 bytes in this order:
  - 0x80 (RS=0).
  - 16 characters for latched[127:64] (RS=1).
  - 0xC0 (RS=0).
  - 16 characters for latched[63:0] (RS=1).
  - Then go to DONE.
- DONE: lasts one cycle with `done`=1 and `busy` still 1, then go to IDLE.
- Nibble-to-ASCII conversion:
  - n in 0..9 maps to 8'h30+n.
  - n in 10..15 maps to 8'h41+(n-10), giving uppercase A-F.
- Byte sub-sequencer:
  - SETUP: `lcd_rs`/`data` are driven and `lcd_e`=0 for SETUP_CYCLES.
  - EHIGH: `lcd_e`=1 for E_HIGH_CYCLES.
  - WAIT: `lcd_e`=0 for CMD_WAIT_CYCLES, or CLEAR_WAIT_CYCLES for byte 0x01.
  - `lcd_rs` and `data` stay constant from the start of SETUP to the end of WAIT.
- Boundary rules:
  - `start` outside IDLE is ignored, not queued; this includes PWRUP, INIT, DRAW and DONE.
  - Changes to `value` after the accepting edge do not affect the redraw in progress.
  - `rst` at any point, including mid-pulse with `lcd_e`=1, forces the reset values on the next edge and restarts at PWRUP.
  - Counters wrap nowhere: each phase counter reloads at phase entry.

## Timing
- Let B = SETUP_CYCLES + E_HIGH_CYCLES + CMD_WAIT_CYCLES and C = SETUP_CYCLES + E_HIGH_CYCLES + CLEAR_WAIT_CYCLES.
- Init: `busy` falls exactly POWERUP_CYCLES + 3B + C cycles after the first edge with `rst`=0.
- Redraw: `done` is high in the cycle that is exactly 34B cycles after the edge that accepted `start`. `busy` falls one cycle later.
- The earliest back-to-back `start` is accepted on the edge after `busy` falls, so the minimum period between accepts is 34B+1 cycles.
- The E high width is exactly E_HIGH_CYCLES. RS/data setup before E rises is exactly SETUP_CYCLES. Hold after E falls is the full WAIT phase.

## Test plan
Small parameters for simulation: SETUP=1, E_HIGH=2, CMD_WAIT=4, CLEAR_WAIT=8, POWERUP=10, giving B=7 and C=11.

- **Reset/init:** deassert `rst`.
  - Bytes captured on the rising edges of `lcd_e` are 38, 0C, 06, 01, all with RS=0.
  - `busy` falls 42 cycles after reset release.
  - `lcd_rw` is 0 throughout.
- **FIPS-197 plaintext:** `value`=128'h00112233445566778899aabbccddeeff, pulse `start`.
  - Captured stream is 0x80, then "0011223344556677" with RS=1, then 0xC0, then "8899AABBCCDDEEFF".
  - `done` pulses 238 cycles after the accept edge.
- **All nibbles:** `value`=128'h0123456789abcdeffedcba9876543210.
  - Line 1 is "0123456789ABCDEF".
  - Line 2 is "FEDCBA9876543210".
  - This checks the 9->'9' (0x39) and A->'A' (0x41) boundary.
- **Ignored start:** hold `start`=1 during init and during a redraw, and change `value` mid-redraw.
  - Exactly one redraw runs per IDLE acceptance.
  - Displayed characters match the value latched at acceptance.
- **Reset mid-pulse:** assert `rst` while `lcd_e`=1 in DRAW.
  - On the next edge, `lcd_e`=0, `data`=00, `busy`=1 and `done`=0.
  - The full init sequence repeats.
- **Timing check:** on every byte, verify E high for exactly 2 cycles and RS/data stable for 1 cycle before E rises through the end of WAIT.
